// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI responder backed by word-addressed on-chip RAM
module axi_mem_responder #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 14,
    parameter int READ_LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_error
);
    localparam int IW = MEM_DEPTH_LOG2;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 2);

    logic [DATA_WIDTH-1:0] mem [2**IW];

    logic [1:0]    w_state_q, w_state_d;
    logic [3:0]    awid_q, awid_d, awlen_q, awlen_d, wcnt_q, wcnt_d;
    logic [IW-1:0] wptr_q, wptr_d;
    logic          awready_q, wready_q, bvalid_q, perr_q, perr_d;
    logic          mem_we, wbeat_last;

    logic [1:0]            r_state_q, r_state_d;
    logic [3:0]            arid_q, arid_d, arlen_q, arlen_d, rbeat_q, rbeat_d, wait_q, wait_d;
    logic [IW-1:0]         rptr_q, rptr_d;
    logic                  arready_q, rvalid_q, rlast_q, rd_load;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:IW], ARADDR[ADDR_WIDTH-1:IW]};

    // Burst end is decided by the beat counter; WLAST/WID only feed the error flag.
    always_comb begin
        w_state_d  = w_state_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        wcnt_d     = wcnt_q;
        wptr_d     = wptr_q;
        perr_d     = perr_q;
        mem_we     = 1'b0;
        wbeat_last = (wcnt_q == awlen_q);
        case (w_state_q)
            W_IDLE: if (AWVALID && awready_q) begin
                awid_d    = AWID;
                awlen_d   = AWLEN;
                wptr_d    = AWADDR[IW-1:0];
                wcnt_d    = 4'd0;
                w_state_d = W_DATA;
            end
            W_DATA: if (WVALID && wready_q) begin
                mem_we = 1'b1;
                wcnt_d = wcnt_q + 4'd1;
                wptr_d = wptr_q + IW'(1);
                if ((WLAST != wbeat_last) || (WID != awid_q))
                    perr_d = 1'b1;
                if (wbeat_last)
                    w_state_d = W_RESP;
            end
            W_RESP: if (bvalid_q && BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            awlen_q   <= '0;
            wcnt_q    <= '0;
            wptr_q    <= '0;
            perr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
            wcnt_q    <= wcnt_d;
            wptr_q    <= wptr_d;
            perr_q    <= perr_d;
            awready_q <= (w_state_d == W_IDLE);
            wready_q  <= (w_state_d == W_DATA);
            bvalid_q  <= (w_state_d == W_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr_q] <= WDATA;
    end

    // RDATA is loaded only when a new beat is presented, so it holds through stalls.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        rbeat_d   = rbeat_q;
        rptr_d    = rptr_q;
        wait_d    = wait_q;
        rd_load   = 1'b0;
        case (r_state_q)
            R_IDLE: if (ARVALID && arready_q) begin
                arid_d  = ARID;
                arlen_d = ARLEN;
                rbeat_d = 4'd0;
                rptr_d  = ARADDR[IW-1:0];
                wait_d  = 4'd0;
                if (READ_LATENCY <= 1) begin
                    r_state_d = R_DATA;
                    rd_load   = 1'b1;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == WAIT_LAST) begin
                    r_state_d = R_DATA;
                    rd_load   = 1'b1;
                end
            end
            R_DATA: if (rvalid_q && RREADY) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    rbeat_d = rbeat_q + 4'd1;
                    rptr_d  = rptr_q + IW'(1);
                    rd_load = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            arlen_q   <= '0;
            rbeat_q   <= '0;
            rptr_q    <= '0;
            wait_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            rbeat_q   <= rbeat_d;
            rptr_q    <= rptr_d;
            wait_q    <= wait_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            if (rd_load) begin
                rdata_q <= mem[rptr_d];
                rlast_q <= (rbeat_d == arlen_d);
            end
        end
    end

    assign AWREADY        = awready_q;
    assign WREADY         = wready_q;
    assign BVALID         = bvalid_q;
    assign BID            = awid_q;
    assign ARREADY        = arready_q;
    assign RVALID         = rvalid_q;
    assign RLAST          = rlast_q;
    assign RID            = arid_q;
    assign RDATA          = rdata_q;
    assign protocol_error = perr_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed self-checking bench for axi_mem_responder
module tb_axi_mem_responder;
    localparam int RL    = 2;
    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, protocol_error;
    logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
    logic [25:0] AWADDR, ARADDR;
    logic [31:0] WDATA, RDATA;

    int checks = 0;
    int errors = 0;
    logic [31:0] wbuf [16];
    logic [31:0] model [int];

    axi_mem_responder #(.READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                            input logic [3:0] wid, input int bad_last);
        int n;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len;
        n = 0;
        while (!AWREADY && n < 100) begin tick(); n++; end
        if (n >= 100) check("aw_timeout", 0, 1);
        tick();
        AWVALID = 1'b0;
        check("aw_wready", {AWREADY, WREADY}, 2'b01);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1; WDATA = wbuf[i]; WID = wid;
            WLAST  = (i == int'(len)) || (i == bad_last);
            n = 0;
            while (!WREADY && n < 100) begin tick(); n++; end
            if (n >= 100) check("w_timeout", 0, 1);
            tick();
            model[(int'(addr) + i) % DEPTH] = wbuf[i];
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("b_after_last", {WREADY, BVALID}, 2'b01);
        check("bid", BID, id);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("b_done", {AWREADY, BVALID}, 2'b10);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [25:0] addr, input logic [3:0] len,
                           input bit toggle, input bit chk_lat);
        logic [31:0] exp [16];
        logic [31:0] held;
        int n, beat, cyc, idx;
        for (int i = 0; i < 16; i++) begin
            idx = (int'(addr) + i) % DEPTH;
            exp[i] = model.exists(idx) ? model[idx] : 32'h0;
        end
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len;
        n = 0;
        while (!ARREADY && n < 100) begin tick(); n++; end
        if (n >= 100) check("ar_timeout", 0, 1);
        tick();
        ARVALID = 1'b0;
        check("arready_low", ARREADY, 0);
        n = 1;
        while (!RVALID && n < 100) begin tick(); n++; end
        if (chk_lat) check("read_latency", n, RL);
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 200) begin
            RREADY = !(toggle && (cyc % 2 == 1));
            if (RREADY) begin
                check("rvalid", RVALID, 1);
                check("rdata", RDATA, exp[beat]);
                check("rlast", RLAST, beat == int'(len));
                check("rid", RID, id);
                tick();
                beat++;
            end else begin
                held = RDATA;
                tick();
                check("rdata_stall", RDATA, held);
                check("rvalid_stall", RVALID, 1);
            end
            cyc++;
        end
        RREADY = 1'b0;
        if (cyc >= 200) check("r_timeout", 0, 1);
        check("r_done", {RVALID, ARREADY}, 2'b01);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
        WVALID = 0; WLAST = 0; WID = 0; WDATA = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;
        repeat (3) tick();
        check("rst_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, protocol_error}, 7'b0);
        check("rst_data", {BID, RID, RDATA}, 40'h0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {AWREADY, ARREADY}, 2'b00);
        tick();
        check("ready_after_edge", {AWREADY, ARREADY}, 2'b11);

        wbuf[0] = 32'hDEADBEEF;
        do_write(4'd3, 26'h10, 4'd0, 4'd3, -1);
        do_read(4'd5, 26'h10, 4'd0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) wbuf[i] = 32'h100 + i;
        do_write(4'd6, 26'h100, 4'd15, 4'd6, -1);
        do_read(4'd7, 26'h100, 4'd15, 1'b1, 1'b1);
        check("perr_clean", protocol_error, 0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        do_write(4'd1, 26'h20, 4'd3, 4'd1, -1);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + i;
        fork
            do_write(4'd2, 26'h20, 4'd3, 4'd2, -1);
            do_read(4'd4, 26'h20, 4'd3, 1'b0, 1'b1);
        join
        do_read(4'd4, 26'h20, 4'd3, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + i;
        do_write(4'd1, 26'h40, 4'd3, 4'd1, 1);
        check("perr_wlast", protocol_error, 1);
        for (int i = 0; i < 2; i++) wbuf[i] = 32'hF0 + i;
        do_write(4'd2, 26'h50, 4'd1, 4'd9, -1);
        check("perr_sticky", protocol_error, 1);
        do_read(4'd0, 26'h40, 4'd3, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + i;
        do_write(4'd8, 26'd16382, 4'd3, 4'd8, -1);
        do_read(4'd9, 26'd16382, 4'd3, 1'b0, 1'b0);
        do_read(4'd9, 26'd0, 4'd0, 1'b0, 1'b0);
        do_read(4'd9, 26'd16383, 4'd0, 1'b0, 1'b0);

        ARVALID = 1'b1; ARID = 4'd7; ARADDR = 26'h100; ARLEN = 4'd7;
        n = 0;
        while (!ARREADY && n < 100) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 100) begin tick(); n++; end
        RREADY = 1'b1;
        tick();
        tick();
        check("beat2_data", RDATA, 32'h102);
        rst = 1'b1;
        #1;
        check("rst_mid_read", {RVALID, ARREADY, AWREADY, protocol_error}, 4'b0000);
        RREADY = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_release", {ARREADY, RVALID}, 2'b10);
        RREADY = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RVALID) n++;
        end
        RREADY = 1'b0;
        check("no_stale_beats", n, 0);
        do_read(4'd3, 26'h104, 4'd1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI responder (slave) that terminates the core's single external AXI port, i.e. the far end of the AW/W/B/AR/R channels driven by the memory arbiter. It backs the port with a word-addressed on-chip RAM. It serves one write burst and one read burst concurrently through independent state machines, with configurable read latency. It is used as the memory model for simulation and as the FPGA-side main memory.

## Interface
- `ADDR_WIDTH`, 26: AXI address width; addresses are word addresses.
- `DATA_WIDTH`, 32: beat width.
- `MEM_DEPTH_LOG2`, 14: RAM holds 2^MEM_DEPTH_LOG2 words.
- `READ_LATENCY`, 2: cycles from AR handshake to first RVALID; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `AWVALID` in 1, `AWREADY` out 1, `AWID` in 4, `AWLEN` in 4, `AWADDR` in ADDR_WIDTH: write address channel; burst length is AWLEN+1.
- `WVALID` in 1, `WREADY` out 1, `WLAST` in 1, `WID` in 4, `WDATA` in DATA_WIDTH: write data channel.
- `BVALID` out 1, `BREADY` in 1, `BID` out 4: write response channel.
- `ARVALID` in 1, `ARREADY` out 1, `ARID` in 4, `ARLEN` in 4, `ARADDR` in ADDR_WIDTH: read address channel.
- `RVALID` out 1, `RREADY` in 1, `RLAST` out 1, `RID` out 4, `RDATA` out DATA_WIDTH: read data channel.
- `protocol_error` out 1: sticky flag; cleared only by `rst`.

## Operation
- All outputs are registered. While `rst` is high, every output is 0. RAM contents are not reset.
- Beat i of a burst accesses RAM index (ADDR + i) mod 2^MEM_DEPTH_LOG2, using the low address bits. The index wraps silently past the top of the RAM.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, AWADDR and AWLEN, clear the beat counter, go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes WDATA to the RAM and increments the counter. On the beat where counter == AWLEN, go to W_RESP.
  - W_RESP: BVALID=1 and BID = latched AWID. On BREADY, return to W_IDLE.
- Write burst end is set by the beat count alone. Set protocol_error if any of these occur:
  - WLAST=1 on a non-final beat.
  - WLAST=0 on the final beat.
  - WID differs from the latched AWID.
  - The offending beat is still written.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID, ARADDR and ARLEN, go to R_WAIT.
  - R_WAIT: count READ_LATENCY-1 cycles while pre-loading RDATA = mem[ARADDR], then go to R_DATA.
  - R_DATA: RVALID=1, RID = latched ARID, RLAST = (beat == ARLEN). On RR handshake of a non-final beat, load the next word into RDATA. On handshake of the final beat, go to R_IDLE.
- With RVALID=1 and RREADY=0, RDATA, RLAST and RID hold stable.
- The read and write FSMs run independently. If a read and a write hit the same RAM index on the same edge, the read returns the old data.
- `rst` asserted mid-burst aborts both FSMs to IDLE immediately. The partial write stays in RAM and no B or R response is issued.

## Timing
- Ready signals rise on the first edge after `rst` deasserts.
- Write: AW handshake at edge 0 → AWREADY=0 and WREADY=1 from cycle 1.
  - Beats are accepted on consecutive edges when WVALID is held.
  - The edge of the last beat sets WREADY=0 and BVALID=1.
  - The B handshake edge sets BVALID=0 and AWREADY=1.
  - A zero-stall burst of N beats therefore occupies N+2 cycles from AW to B handshake.
- Read: AR handshake at edge 0 → ARREADY=0. RVALID=1 with beat 0 from cycle READ_LATENCY.
  - With RREADY held high, one beat is delivered per cycle.
  - The edge of the final beat's handshake sets RVALID=0 and ARREADY=1.
- Only one write and one read are outstanding at a time. AWREADY and ARREADY stay low until the respective response completes.

## Test plan
- Single write, then read:
  - Stimulus: AW(id 3, addr 0x10, len 0), W 0xDEADBEEF with WLAST=1, then AR(id 5, addr 0x10, len 0).
  - Response: BID=3. At READ_LATENCY cycles after the AR handshake, RVALID=1, RDATA=0xDEADBEEF, RLAST=1, RID=5.
- 16-beat bursts:
  - Stimulus: write 0x100..0x10F with data = addr, then read back with RREADY toggled every other cycle.
  - Response: data is in order, RDATA is stable during stalls, RLAST only on beat 15, protocol_error=0.
- Concurrent channels:
  - Stimulus: a 4-beat read of 0x20 starts while a 4-beat write to 0x20 is in progress.
  - Response: for each beat, the read returns the old value if it arrives on the same edge as the write and the new value if after; both bursts complete.
- Protocol violations:
  - Stimulus: AWLEN=3 with WLAST on beat 1; then a second burst with a mismatched WID.
  - Response: all 4 beats are still written, protocol_error=1 and stays set, BVALID arrives after beat 3.
- Wrap-around:
  - Stimulus: AWADDR = 2^14-2 with len 3.
  - Response: the words land at indices 16382, 16383, 0, 1, and readback matches.
- Reset mid-read:
  - Stimulus: assert `rst` during beat 2 of an 8-beat read.
  - Response: RVALID=0 immediately. After release, ARREADY=1 one edge later and no stale beats are issued.
